// File: rtl/pulse_sync_rcv.sv
// rtl/pulse_sync_rcv.sv - toggle pulse synchronizer receiver with pending-event counter
module pulse_sync_rcv #(
    parameter int SYNC_STAGES = 2,
    parameter int EVT_CNT_W   = 4
) (
    input  logic                 clk_src,
    input  logic                 rst_n,
    input  logic                 tq_in,
    output logic                 ack,
    output logic                 evt_pulse,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [EVT_CNT_W-1:0] evt_pend,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int ARM_W = 3;
    localparam logic [ARM_W-1:0]     ARM_LAST = ARM_W'(SYNC_STAGES);
    localparam logic [EVT_CNT_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tog_q;
    logic                   armed_q;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic [ARM_W-1:0]       arm_cnt_d;
    logic                   evt_pulse_q;
    logic [EVT_CNT_W-1:0]   pend_q;
    logic [EVT_CNT_W-1:0]   pend_d;
    logic                   ovf_q;
    logic                   ovf_d;
    logic                   armed_d;
    logic                   tog_edge;
    logic                   pop;
    logic                   drop;

    // Only the last sync stage is observed; earlier stages may be metastable.
    assign tog_edge = armed_q & (sync_q[SYNC_STAGES-1] ^ tog_q);
    assign pop      = evt_valid & evt_ready;
    assign drop     = tog_edge & ~pop & (pend_q == PEND_MAX);

    always_comb begin
        pend_d = pend_q;
        if (tog_edge && !pop && pend_q != PEND_MAX) begin
            pend_d = pend_q + 1'b1;
        end else if (!tog_edge && pop) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    assign ovf_d = (ovf_q & ~ovf_clr) | drop;

    // Arming masks the edge that a nonzero tq_in level would fake at reset release.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!armed_q) begin
            arm_cnt_d = arm_cnt_q + 1'b1;
            if (arm_cnt_q == ARM_LAST) begin
                armed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_src or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            tog_q       <= 1'b0;
            armed_q     <= 1'b0;
            arm_cnt_q   <= '0;
            evt_pulse_q <= 1'b0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], tq_in};
            tog_q       <= sync_q[SYNC_STAGES-1];
            armed_q     <= armed_d;
            arm_cnt_q   <= arm_cnt_d;
            evt_pulse_q <= tog_edge;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
        end
    end

    assign ack       = tog_q;
    assign evt_pulse = evt_pulse_q;
    assign evt_valid = (pend_q != '0);
    assign evt_pend  = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pulse_sync_rcv.sv
// tb/tb_pulse_sync_rcv.sv - scoreboard bench for pulse_sync_rcv
module tb_pulse_sync_rcv;

    localparam int N = 2;
    localparam int W = 4;

    logic         clk_src = 1'b0;
    logic         rst_n;
    logic         tq_in;
    logic         ack;
    logic         evt_pulse;
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] evt_pend;
    logic         ovf;
    logic         ovf_clr;

    int cyc = 0;
    int total = 0;
    int passed = 0;
    int exp_q[$];

    pulse_sync_rcv #(.SYNC_STAGES(N), .EVT_CNT_W(W)) dut (
        .clk_src   (clk_src),
        .rst_n     (rst_n),
        .tq_in     (tq_in),
        .ack       (ack),
        .evt_pulse (evt_pulse),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_pend  (evt_pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk_src = ~clk_src;
    always @(posedge clk_src) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_src);
    endtask

    // Toggle at a negedge; the pulse is expected N edges after the capturing edge.
    task automatic toggle();
        tq_in = ~tq_in;
        exp_q.push_back(cyc + 1 + N);
        tick();
    endtask

    // Monitor: every evt_pulse must match the oldest expected pulse cycle.
    always @(negedge clk_src) begin
        if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            total++;
            $display("FAIL missed_pulse: expected at cycle %0d, now %0d", exp_q[0], cyc);
            void'(exp_q.pop_front());
        end
        if (evt_pulse) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL spurious_pulse: pulse at cycle %0d, none expected", cyc);
            end else begin
                chk("pulse_cycle", cyc, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_ack"}, int'(ack), 0);
        chk({name, "_pulse"}, int'(evt_pulse), 0);
        chk({name, "_valid"}, int'(evt_valid), 0);
        chk({name, "_pend"}, int'(evt_pend), 0);
        chk({name, "_ovf"}, int'(ovf), 0);
    endtask

    task automatic drain(input int n);
        evt_ready = 1'b1;
        tick(n);
        evt_ready = 1'b0;
    endtask

    initial begin
        int c;
        rst_n = 1'b0; tq_in = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(10);

        // single toggle
        toggle();
        tick(2);
        chk("t1_ack", int'(ack), 1);
        chk("t1_pend", int'(evt_pend), 1);
        chk("t1_valid", int'(evt_valid), 1);
        drain(1);
        chk("t1_drain_pend", int'(evt_pend), 0);
        chk("t1_drain_valid", int'(evt_valid), 0);

        // release reset with tq_in already high
        rst_n = 1'b0; tq_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("t2_ack_e2", int'(ack), 0);
        tick(1);
        chk("t2_ack_e3", int'(ack), 1);
        tick(5);
        chk("t2_pend_noevt", int'(evt_pend), 0);
        toggle();
        tick(N + 1);
        chk("t2_pend_one", int'(evt_pend), 1);
        chk("t2_ack_low", int'(ack), 0);
        drain(1);

        // five back-to-back toggles
        for (int i = 0; i < 5; i++) toggle();
        tick(N + 1);
        chk("t3_pend5", int'(evt_pend), 5);
        evt_ready = 1'b1;
        tick(4);
        chk("t3_valid_after4", int'(evt_valid), 1);
        tick(1);
        chk("t3_pend0", int'(evt_pend), 0);
        chk("t3_valid0", int'(evt_valid), 0);
        tick(1);
        evt_ready = 1'b0;
        chk("t3_no_wrap", int'(evt_pend), 0);

        // saturation and overflow
        for (int i = 0; i < 16; i++) toggle();
        tick(N + 1);
        chk("t4_pend_sat", int'(evt_pend), 15);
        chk("t4_ovf_set", int'(ovf), 1);
        tq_in = ~tq_in;
        exp_q.push_back(cyc + 1 + N);
        tick(N);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t4_set_wins", int'(ovf), 1);
        chk("t4_pend_hold", int'(evt_pend), 15);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", int'(ovf), 0);
        drain(15);
        chk("t4_drained", int'(evt_pend), 0);

        // edge and pop in the same cycle
        for (int i = 0; i < 3; i++) toggle();
        tick(N + 1);
        chk("t5_pend3", int'(evt_pend), 3);
        tq_in = ~tq_in;
        exp_q.push_back(cyc + 1 + N);
        tick(N);
        evt_ready = 1'b1;
        tick(1);
        chk("t5_edge_pop", int'(evt_pend), 3);
        tick(1);
        chk("t5_dec", int'(evt_pend), 2);
        tick(2);
        evt_ready = 1'b0;
        chk("t5_zero", int'(evt_pend), 0);

        // reset mid-stream
        for (int i = 0; i < 7; i++) toggle();
        tick(N + 1);
        chk("t6_pend7", int'(evt_pend), 7);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        tick(2);
        rst_n = 1'b1;
        tick(10);
        chk("t6_pend_after", int'(evt_pend), 0);
        chk("t6_ack_level", int'(ack), int'(tq_in));
        toggle();
        tick(N + 1);
        chk("t6_post_evt", int'(evt_pend), 1);
        c = exp_q.size();
        chk("queue_empty", c, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
